// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM:
// FSM state encoding, opcode values, ALUOp classes, fault codes and the
// bundle of datapath control strobes produced by the output decoder.
package multicycle_controller_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_RI  = 2'b10;
   localparam logic [1:0] ALUOP_LUI = 2'b11;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // One-hot instruction class; exactly one bit is set for any opcode.
   typedef struct packed {
      logic r;
      logic i;
      logic lui;
      logic lw;
      logic sw;
      logic br;
      logic jal;
      logic jalr;
      logic illegal;
   } op_class_t;

   // Datapath control strobes (fault is carried separately, it is state).
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       alu_src;
      logic       memto_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jsel;
      logic       jalr_sel;
      logic       rw_sel;
      logic [1:0] alu_op;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller side uses
// the master modport; the datapath (or a bench) uses the slave modport.
interface multicycle_controller_if #(
   parameter int ALUOP_W = 2
);
   logic [6:0]         Opcode;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_we;
   logic               IorD;
   logic               IRWrite;
   logic               MdrWrite;
   logic               PCWrite;
   logic               ALUSrc;
   logic               MemtoReg;
   logic               RegWrite;
   logic               MemRead;
   logic               MemWrite;
   logic               Branch;
   logic               JSel;
   logic               JalrSel;
   logic               RWSel;
   logic [ALUOP_W-1:0] ALUOp;
   logic               instr_done;
   logic [1:0]         fault;

   modport master (
      input  Opcode, mem_ready,
      output mem_req, mem_we, IorD, IRWrite, MdrWrite, PCWrite, ALUSrc,
             MemtoReg, RegWrite, MemRead, MemWrite, Branch, JSel, JalrSel,
             RWSel, ALUOp, instr_done, fault
   );

   modport slave (
      output Opcode, mem_ready,
      input  mem_req, mem_we, IorD, IRWrite, MdrWrite, PCWrite, ALUSrc,
             MemtoReg, RegWrite, MemRead, MemWrite, Branch, JSel, JalrSel,
             RWSel, ALUOp, instr_done, fault
   );
endinterface

// File: rtl/multicycle_controller_opcode_class_decode.sv
// Combinational opcode classifier: maps IR[6:0] to a one-hot class vector.
// Anything not in the supported RV32I subset is flagged illegal.
module multicycle_controller_opcode_class_decode
   import multicycle_controller_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_t  class_o
);

   // Classify the opcode; default covers every unsupported encoding.
   always_comb begin
      class_o = '0;
      case (opcode_i)
         OP_R:    class_o.r       = 1'b1;
         OP_I:    class_o.i       = 1'b1;
         OP_LUI:  class_o.lui     = 1'b1;
         OP_LW:   class_o.lw      = 1'b1;
         OP_SW:   class_o.sw      = 1'b1;
         OP_BR:   class_o.br      = 1'b1;
         OP_JAL:  class_o.jal     = 1'b1;
         OP_JALR: class_o.jalr    = 1'b1;
         default: class_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a
// memory ready/wait handshake, request timeout, illegal-opcode handling
// and a one-cycle retire pulse. Controls are decoded from state + IR
// opcode (+ mem_ready for the handshake strobes) and are all 0 in reset.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT     = 16,
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int ALUOP_W         = 2
) (
   input logic                      clk,
   input logic                      reset,
   multicycle_controller_if.master  bus
);

   // A zero timeout disables the counter; keep it 1 bit wide so it exists.
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [1:0]       fault_q,    fault_d;
   op_class_t        cls_s;
   ctrl_t            ctrl_s;
   logic             timeout_hit_s;

   multicycle_controller_opcode_class_decode u_class_decode (
      .opcode_i (bus.Opcode),
      .class_o  (cls_s)
   );

   // Last permitted unready cycle of the current memory request.
   assign timeout_hit_s = TIMEOUT_EN && (wait_cnt_q == CNT_LAST);

   // Next-state, wait counter and fault logic. The counter is zero in every
   // state except while a request is waiting, so it starts cleared on entry
   // to FETCH and MEM.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      fault_d    = fault_q;
      case (state_q)
         FETCH: begin
            if (bus.mem_ready) begin
               state_d = DECODE;
            end else if (timeout_hit_s) begin
               state_d = TRAP;
               fault_d = FAULT_TIMEOUT;
            end else begin
               wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
         end
         DECODE: begin
            if (cls_s.illegal) begin
               if (TRAP_ON_ILLEGAL) begin
                  state_d = TRAP;
                  fault_d = FAULT_ILLEGAL;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cls_s.lw || cls_s.sw) begin
               state_d = MEM;
            end else if (cls_s.r || cls_s.i || cls_s.lui) begin
               state_d = WB;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            if (bus.mem_ready) begin
               state_d = cls_s.lw ? WB : FETCH;
            end else if (timeout_hit_s) begin
               state_d = TRAP;
               fault_d = FAULT_TIMEOUT;
            end else begin
               wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
         end
         WB: begin
            state_d = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = FETCH;
            fault_d = FAULT_NONE;
         end
      endcase
   end

   // State, wait counter and sticky fault registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
         fault_q    <= FAULT_NONE;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   // Control decode from state and IR opcode; everything idle during reset.
   always_comb begin
      ctrl_s = '0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               ctrl_s.mem_req  = 1'b1;
               ctrl_s.mem_read = 1'b1;
               ctrl_s.ir_write = bus.mem_ready;
               ctrl_s.pc_write = bus.mem_ready;
            end
            DECODE: begin
               ctrl_s.instr_done = cls_s.illegal && !TRAP_ON_ILLEGAL;
            end
            EXEC: begin
               if (cls_s.r) begin
                  ctrl_s.alu_op = ALUOP_RI;
               end else if (cls_s.i) begin
                  ctrl_s.alu_op  = ALUOP_RI;
                  ctrl_s.alu_src = 1'b1;
               end else if (cls_s.lui) begin
                  ctrl_s.alu_op  = ALUOP_LUI;
                  ctrl_s.alu_src = 1'b1;
               end else if (cls_s.lw || cls_s.sw) begin
                  ctrl_s.alu_op  = ALUOP_MEM;
                  ctrl_s.alu_src = 1'b1;
               end else if (cls_s.br) begin
                  ctrl_s.branch     = 1'b1;
                  ctrl_s.alu_op     = ALUOP_BR;
                  ctrl_s.instr_done = 1'b1;
               end else if (cls_s.jal || cls_s.jalr) begin
                  ctrl_s.jsel       = 1'b1;
                  ctrl_s.rw_sel     = 1'b1;
                  ctrl_s.reg_write  = 1'b1;
                  ctrl_s.pc_write   = 1'b1;
                  ctrl_s.jalr_sel   = cls_s.jalr;
                  ctrl_s.alu_src    = cls_s.jalr;
                  ctrl_s.instr_done = 1'b1;
               end else begin
                  ctrl_s = '0;
               end
            end
            MEM: begin
               ctrl_s.mem_req    = 1'b1;
               ctrl_s.iord       = 1'b1;
               ctrl_s.mem_we     = cls_s.sw;
               ctrl_s.mem_write  = cls_s.sw;
               ctrl_s.mem_read   = cls_s.lw;
               ctrl_s.mdr_write  = bus.mem_ready && cls_s.lw;
               ctrl_s.instr_done = bus.mem_ready && cls_s.sw;
            end
            WB: begin
               ctrl_s.reg_write  = 1'b1;
               ctrl_s.memto_reg  = cls_s.lw;
               ctrl_s.rw_sel     = 1'b0;
               ctrl_s.instr_done = 1'b1;
            end
            TRAP: begin
               ctrl_s = '0;
            end
            default: begin
               ctrl_s = '0;
            end
         endcase
      end else begin
         ctrl_s = '0;
      end
   end

   assign bus.mem_req    = ctrl_s.mem_req;
   assign bus.mem_we     = ctrl_s.mem_we;
   assign bus.IorD       = ctrl_s.iord;
   assign bus.IRWrite    = ctrl_s.ir_write;
   assign bus.MdrWrite   = ctrl_s.mdr_write;
   assign bus.PCWrite    = ctrl_s.pc_write;
   assign bus.ALUSrc     = ctrl_s.alu_src;
   assign bus.MemtoReg   = ctrl_s.memto_reg;
   assign bus.RegWrite   = ctrl_s.reg_write;
   assign bus.MemRead    = ctrl_s.mem_read;
   assign bus.MemWrite   = ctrl_s.mem_write;
   assign bus.Branch     = ctrl_s.branch;
   assign bus.JSel       = ctrl_s.jsel;
   assign bus.JalrSel    = ctrl_s.jalr_sel;
   assign bus.RWSel      = ctrl_s.rw_sel;
   assign bus.ALUOp      = ALUOP_W'(ctrl_s.alu_op);
   assign bus.instr_done = ctrl_s.instr_done;
   assign bus.fault      = reset ? FAULT_NONE : fault_q;

endmodule
